// File: rtl/sparse_mac_accum.sv
// sparse_mac_accum: resolves compressed operand indices by prefix popcount for each
// matched bitmap position, multiplies and accumulates, and emits each dot product through a valid/ready register.
module sparse_mac_accum #(
  parameter int CHUNK_SIZE = 32,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         chunk_start_i,
  input  logic                         dot_last_i,
  input  logic [CHUNK_SIZE-1:0]        ifm_bitmap_i,
  input  logic [CHUNK_SIZE-1:0]        filter_bitmap_i,
  input  logic [CHUNK_SIZE*DATA_W-1:0] ifm_data_i,
  input  logic [CHUNK_SIZE*DATA_W-1:0] filter_data_i,
  input  logic                         match_valid_i,
  input  logic [$clog2(CHUNK_SIZE)-1:0] match_addr_i,
  input  logic                         match_last_i,
  output logic                         ready_o,
  output logic                         out_valid_o,
  output logic signed [ACC_W-1:0]      out_data_o,
  input  logic                         out_ready_i
);
  localparam int AW = $clog2(CHUNK_SIZE);
  localparam int VW = CHUNK_SIZE*DATA_W;
  logic [CHUNK_SIZE-1:0] ifm_bm_q, flt_bm_q, ifm_bm, flt_bm;
  logic [VW-1:0] ifm_d_q, flt_d_q, ifm_d, flt_d;
  logic final_q, cur_final, beat, take;
  logic [AW-1:0] ifm_idx, flt_idx;
  logic signed [DATA_W-1:0] s1_a, s1_b;
  logic s1_pv, s1_end;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, addend, sum;
  assign ready_o   = ~(out_valid_o & ~out_ready_i);
  assign beat      = (match_valid_i | match_last_i) & ready_o;
  assign take      = beat & chunk_start_i;
  // The first beat of a chunk works on the live bus, later beats on the captured copy.
  assign ifm_bm    = chunk_start_i ? ifm_bitmap_i : ifm_bm_q;
  assign flt_bm    = chunk_start_i ? filter_bitmap_i : flt_bm_q;
  assign ifm_d     = chunk_start_i ? ifm_data_i : ifm_d_q;
  assign flt_d     = chunk_start_i ? filter_data_i : flt_d_q;
  assign cur_final = chunk_start_i ? dot_last_i : final_q;
  always_comb begin
    ifm_idx = '0;
    flt_idx = '0;
    for (int i = 0; i < CHUNK_SIZE; i++)
      if (i < int'(match_addr_i)) begin
        ifm_idx = ifm_idx + AW'(ifm_bm[i]);
        flt_idx = flt_idx + AW'(flt_bm[i]);
      end
  end
  assign prod   = s1_a * s1_b;
  assign addend = s1_pv ? ACC_W'(prod) : '0;
  assign sum    = acc + addend;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ifm_bm_q    <= '0;
      flt_bm_q    <= '0;
      ifm_d_q     <= '0;
      flt_d_q     <= '0;
      final_q     <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_pv       <= 1'b0;
      s1_end      <= 1'b0;
      acc         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (ready_o) begin
      if (take) begin
        ifm_bm_q <= ifm_bitmap_i;
        flt_bm_q <= filter_bitmap_i;
        ifm_d_q  <= ifm_data_i;
        flt_d_q  <= filter_data_i;
        final_q  <= dot_last_i;
      end
      s1_a   <= ifm_d[ifm_idx*DATA_W +: DATA_W];
      s1_b   <= flt_d[flt_idx*DATA_W +: DATA_W];
      s1_pv  <= beat & match_valid_i;
      s1_end <= beat & match_last_i & cur_final;
      // While ready, a held result is being taken, so valid simply follows the end flag.
      out_valid_o <= s1_end;
      if (s1_end) out_data_o <= sum;
      acc <= s1_end ? '0 : sum;
    end
  end
endmodule

// File: tb/tb_sparse_mac_accum.sv
// tb_sparse_mac_accum: dense-vector reference model driving two instances (ACC_W 24 and 16)
// through encoder-style beats with random and directed back-pressure.
module tb_sparse_mac_accum;
  localparam int CS = 32;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic chunk_start = 1'b0, dot_last = 1'b0, match_valid = 1'b0, match_last = 1'b0, out_ready = 1'b1;
  logic [CS-1:0] ifm_bm = '0, flt_bm = '0;
  logic [CS*DW-1:0] ifm_d = '0, flt_d = '0;
  logic [4:0] match_addr = '0;
  logic ready_a, ready_b, valid_a, valid_b;
  logic signed [23:0] data_a;
  logic signed [15:0] data_b;
  sparse_mac_accum #(.CHUNK_SIZE(CS), .DATA_W(DW), .ACC_W(24)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .chunk_start_i(chunk_start), .dot_last_i(dot_last),
    .ifm_bitmap_i(ifm_bm), .filter_bitmap_i(flt_bm), .ifm_data_i(ifm_d), .filter_data_i(flt_d),
    .match_valid_i(match_valid), .match_addr_i(match_addr), .match_last_i(match_last),
    .ready_o(ready_a), .out_valid_o(valid_a), .out_data_o(data_a), .out_ready_i(out_ready));
  sparse_mac_accum #(.CHUNK_SIZE(CS), .DATA_W(DW), .ACC_W(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .chunk_start_i(chunk_start), .dot_last_i(dot_last),
    .ifm_bitmap_i(ifm_bm), .filter_bitmap_i(flt_bm), .ifm_data_i(ifm_d), .filter_data_i(flt_d),
    .match_valid_i(match_valid), .match_addr_i(match_addr), .match_last_i(match_last),
    .ready_o(ready_b), .out_valid_o(valid_b), .out_data_o(data_b), .out_ready_i(out_ready));
  int tests = 0;
  int fails = 0;
  int mode = 0;
  longint exp_q[$];
  logic signed [DW-1:0] d_ifm[4][CS];
  logic signed [DW-1:0] d_flt[4][CS];
  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Consumer: picks out_ready each cycle and scores every completed handshake.
  initial begin
    logic held_v;
    longint held, e;
    logic signed [23:0] e24;
    logic signed [15:0] e16;
    held_v = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (rst_n && valid_a) begin
        if (held_v) check("hold_stable", data_a, held);
        if (out_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else begin
            e = exp_q.pop_front();
            e24 = e[23:0];
            e16 = e[15:0];
            check("out24", data_a, e24);
            check("out16", data_b, e16);
            check("valid16", valid_b, 1);
          end
        end else begin
          held_v = 1'b1;
          held = data_a;
        end
      end else held_v = 1'b0;
    end
  end
  task automatic finish_now();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask
  task automatic beat(input bit st, input bit dl, input bit v, input bit l, input int addr,
                      input logic [CS-1:0] ib, input logic [CS-1:0] fb,
                      input logic [CS*DW-1:0] id, input logic [CS*DW-1:0] fd);
    int n = 0;
    @(negedge clk);
    chunk_start = st; dot_last = dl; match_valid = v; match_last = l; match_addr = 5'(addr);
    ifm_bm = ib; flt_bm = fb; ifm_d = id; flt_d = fd;
    #1;
    while (!ready_a) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 2000) begin
        check("ready_timeout", 0, 1);
        finish_now();
      end
    end
  endtask
  task automatic idle();
    @(negedge clk);
    chunk_start = 1'b0; match_valid = 1'b0; match_last = 1'b0;
  endtask
  task automatic send_chunk(input int c, input bit fin);
    logic [CS-1:0] ib = '0, fb = '0;
    logic [CS*DW-1:0] id = '0, fd = '0;
    int ki = 0, kf = 0;
    int m[$];
    for (int p = 0; p < CS; p++) begin
      if (d_ifm[c][p] != 0) begin ib[p] = 1'b1; id[ki*DW +: DW] = d_ifm[c][p]; ki++; end
      if (d_flt[c][p] != 0) begin fb[p] = 1'b1; fd[kf*DW +: DW] = d_flt[c][p]; kf++; end
      if (d_ifm[c][p] != 0 && d_flt[c][p] != 0) m.push_back(p);
    end
    if (m.size() == 0) beat(1, fin, 0, 1, 0, ib, fb, id, fd);
    else for (int j = 0; j < m.size(); j++)
      beat(j == 0, fin, 1, j == m.size() - 1, m[j], ib, fb, id, fd);
  endtask
  task automatic send_dot(input int nch, input bit gap);
    longint s = 0;
    for (int c = 0; c < nch; c++)
      for (int p = 0; p < CS; p++) s += longint'(d_ifm[c][p]) * longint'(d_flt[c][p]);
    exp_q.push_back(s);
    for (int c = 0; c < nch; c++) send_chunk(c, c == nch - 1);
    if (gap) idle();
  endtask
  task automatic clear();
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < CS; p++) begin d_ifm[c][p] = '0; d_flt[c][p] = '0; end
  endtask
  function automatic logic signed [DW-1:0] nz();
    logic signed [DW-1:0] v = DW'($urandom_range(0, 255));
    return (v == 0) ? 8'sd1 : v;
  endfunction
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || valid_a) && n < 500) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);
  endtask
  initial begin
    clear();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_data16", data_b, 0);
    check("rst_ready", ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    // Matches at 5 and 7: 3*4 + (-2)*5 = 2, two cycles after the final beat.
    d_ifm[0][4] = 11; d_ifm[0][5] = 3; d_ifm[0][6] = 13; d_ifm[0][7] = -2;
    d_flt[0][0] = 9; d_flt[0][2] = 17; d_flt[0][5] = 4; d_flt[0][7] = 5;
    send_dot(1, 1);
    check("lat_early", valid_a, 0);
    @(posedge clk);
    #1;
    check("lat_2", valid_a, 1);
    drain();
    clear();
    d_ifm[0][3] = 7; d_flt[0][3] = 7; d_ifm[0][1] = 20; d_flt[0][30] = 6;
    d_ifm[1][10] = -1; d_flt[1][10] = 9;
    send_dot(2, 1);
    drain();
    clear();
    d_ifm[0][0] = 5; d_flt[0][0] = 1; d_ifm[1][4] = 3; d_flt[1][5] = 8;
    send_dot(2, 1);
    clear();
    d_ifm[0][17] = 2; d_flt[0][17] = 3;
    send_dot(1, 1);
    drain();
    mode = 2;
    clear();
    d_ifm[0][2] = -3; d_flt[0][2] = 7;
    send_dot(1, 1);
    for (int n = 0; n < 50 && !valid_a; n++) @(negedge clk);
    #2;
    check("bp_valid", valid_a, 1);
    check("bp_ready", ready_a, 0);
    check("bp_ready16", ready_b, 0);
    clear();
    d_ifm[0][0] = -128; d_flt[0][0] = -128; d_ifm[0][31] = -128; d_flt[0][31] = -128;
    fork
      send_dot(1, 1);
      begin
        repeat (5) begin
          @(negedge clk);
          #2;
          check("bp_stall_ready", ready_a, 0);
          check("bp_stall_data", data_a, -21);
        end
        mode = 0;
      end
    join
    drain();
    clear();
    d_ifm[0][1] = 4; d_flt[0][1] = 4; d_ifm[0][9] = 2; d_flt[0][9] = 2;
    send_chunk(0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid_a, 0);
    check("arst_data", data_a, 0);
    check("arst_ready", ready_a, 1);
    @(negedge clk);
    chunk_start = 1'b0; match_valid = 1'b0; match_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_spurious", valid_a, 0);
    send_dot(1, 1);
    drain();
    mode = 1;
    repeat (40) begin
      int nch = $urandom_range(1, 3);
      clear();
      for (int c = 0; c < nch; c++) begin
        int dens = $urandom_range(5, 90);
        for (int p = 0; p < CS; p++) begin
          d_ifm[c][p] = ($urandom_range(0, 99) < dens) ? nz() : 8'sd0;
          d_flt[c][p] = ($urandom_range(0, 99) < dens) ? nz() : 8'sd0;
        end
      end
      send_dot(nch, 1'($urandom_range(0, 1)));
    end
    idle();
    drain();
    finish_now();
  end
endmodule
